alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Moore control FSM that drives every datapath control line for fetch and register-register ALU instructions.
- Replaces the hand-written T0..T5 sequences in datapath benches. It sits directly upstream of datapath and consumes datapath's IR output.
- Executes the fetch cycles (T0-T2), then the execute cycles (T3-T6), then loops back to T0 until halted.

Parameters:
- NREGS, 16, number of general registers; width of Rin/Rout.
- OPW, 5, opcode width; opcode is IR[31:27].

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear_n  in  1  synchronous, active-low reset.
- IR  in  32  instruction register contents. Fields: opcode IR[31:27], Ra IR[26:23] (destination), Rb IR[22:19], Rc IR[18:15].
- stop  in  1  request to halt at the next instruction boundary.
- Rin  out  16  one-hot general-register load enable.
- Rout  out  16  one-hot general-register bus drive.
- PCin, PCout, MARin, MDRin, MDRout, IRin, Yin  out  1 each  datapath register enables.
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO enables.
- IncPC  out  1  ALU increments PC (value taken from the bus).
- Read  out  1  memory read strobe; Mdatain is valid in the same cycle.
- ALUop  out  4  ALU operation select.
- halted  out  1  high while in HALT.

Behaviour:
- Interface: one clock; reset is synchronous and active-low, on ports clock and clear_n.
- Reset: clear_n low at a rising edge forces state to RESET, including mid-instruction. In RESET every output is 0 and ALUop = 0.
- All outputs are decoded combinationally from state and the registered IR fields only. No output depends on stop.
- States: RESET, T0, T1, T2, T3, T4, T5, T6, HALT. The state register is the only sequential storage.
- RESET -> T0 on the first edge with clear_n high.
- T0: PCout, MARin, IncPC, Zlowin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin. IR is valid from T3 onward.
- T3 entry, decoded from IR at end of T2:
  - Legal ALU opcode -> T3.
  - halt (11011) -> HALT.
  - nop (11010) or any illegal opcode -> T0; no register is written.
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], ALUop = decoded value, Zlowin. mul and div also assert Zhighin.
- T5:
  - Normal ops: Zlowout, Rin[Ra]; next state T0.
  - mul/div: Zlowout, LOin, Rin = 0; next state T6.
- T6 (mul/div only): Zhighout, HIin; next state T0.
- Opcode -> ALUop: add 00000->0, sub 00001->1, and 00010->2, or 00011->3, shl 00110->4, shr 00100->5, shra 00101->6, ror 00111->7, rol 01000->8, mul 01111->9, div 10000->10.
- stop:
  - Sampled only on the edge where the FSM would enter T0 (leaving T5, T6, or T2 for nop).
  - If high on that edge, go to HALT instead of T0.
  - stop high at any other time has no effect; the instruction completes.
- HALT: all enables 0, halted = 1. Only clear_n low exits HALT.
- At most one bit of Rin and one bit of Rout is set in any cycle. At most one bus driver (Rout, PCout, MDRout, Zlowout, Zhighout) is active per cycle.
- Ra, Rb, Rc may be equal, e.g. add R3,R3,R3 is legal. Rin and Rout are in different cycles, so there is no conflict.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ADD..OP_HALT);
  - ALUop localparams (ALU_ADD=0 .. ALU_SHRA=6 .. ALU_DIV=10);
  - state encoding;
  - IR field bit positions.
- ALU benches import the same ALUop constants.
- One sub-module: reg_select_decoder, a 4-to-16 one-hot decoder with enable. It is instantiated twice, once for Rin and once for Rout.

Test Plan:
- Reset, then release clear_n, IR = 0x2B820000 (shra R7,R0,R4):
  - T0 and T1 enables exactly as listed above; T2: MDRout, IRin.
  - T3: Rout = 0x0001, Yin.
  - T4: Rout = 0x0010, ALUop = 6, Zlowin.
  - T5: Rin = 0x0080, Zlowout; then T0.
- IR = 0x781A8000 (mul, Rb=3, Rc=5):
  - T3: Rout = 0x0008.
  - T4: Rout = 0x0020, ALUop = 9, Zlowin = Zhighin = 1.
  - T5: LOin, Zlowout, Rin = 0.
  - T6: HIin, Zhighout; then T0.
- IR = 0xD8000000 (halt): after T2 enters HALT, halted = 1, all enables 0 for 10 cycles. Pulsing clear_n low for 1 cycle returns to RESET, then T0.
- IR = 0xF8000000 (illegal opcode 11111): T2 -> T0 directly; Rin stays 0 throughout.
- stop raised during T3 of an add (IR = 0x01090000): T4 and T5 complete with Rin = 0x0004, then HALT instead of T0.
- clear_n low during T4: next cycle is RESET with all outputs 0. No Rin pulse occurs for the aborted instruction.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcode, ALUop, state and IR field definitions
package cpu_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int OPCODE_W = 5;
  localparam int RSEL_W   = 4;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHL  = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       muldiv;
    logic [3:0] aluop;
  } op_info_t;

  function automatic op_info_t decode_op(logic [4:0] op);
    op_info_t info;
    info = '{legal: 1'b1, muldiv: 1'b0, aluop: ALU_ADD};
    case (op)
      OP_ADD:  info.aluop = ALU_ADD;
      OP_SUB:  info.aluop = ALU_SUB;
      OP_AND:  info.aluop = ALU_AND;
      OP_OR:   info.aluop = ALU_OR;
      OP_SHL:  info.aluop = ALU_SHL;
      OP_SHR:  info.aluop = ALU_SHR;
      OP_SHRA: info.aluop = ALU_SHRA;
      OP_ROR:  info.aluop = ALU_ROR;
      OP_ROL:  info.aluop = ALU_ROL;
      OP_MUL:  begin info.aluop = ALU_MUL; info.muldiv = 1'b1; end
      OP_DIV:  begin info.aluop = ALU_DIV; info.muldiv = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - one-hot register select decoder with enable
module reg_select_decoder #(
  parameter int N    = 16,
  parameter int SELW = 4
) (
  input  logic            en_i,
  input  logic [SELW-1:0] sel_i,
  output logic [N-1:0]    onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - Moore control FSM for fetch and reg-reg ALU instructions
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int OPW   = OPCODE_W
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [31:0]      IR,
  input  logic             stop,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             PCin,
  output logic             PCout,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [3:0]       ALUop,
  output logic             halted
);

  state_e state_q, state_d;

  logic [OPW-1:0]    opcode;
  logic [RSEL_W-1:0] ra, rb, rc;
  op_info_t          op_info;
  logic              rin_en, rout_en;
  logic [RSEL_W-1:0] rout_sel;
  state_e            boundary;
  logic [14:0]       unused_ir_bits;

  assign opcode         = IR[OP_LSB +: OPW];
  assign ra             = IR[RA_LSB +: RSEL_W];
  assign rb             = IR[RB_LSB +: RSEL_W];
  assign rc             = IR[RC_LSB +: RSEL_W];
  assign op_info        = decode_op(opcode);
  assign unused_ir_bits = IR[14:0];

  // stop only matters on the edge that would start the next instruction
  assign boundary = stop ? ST_HALT : ST_T0;

  always_ff @(posedge clock) begin
    if (!clear_n) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    PCin     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = ALU_ADD;
    halted   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (op_info.legal)          state_d = ST_T3;
        else if (opcode == OP_HALT) state_d = ST_HALT;
        else                        state_d = boundary;
      end
      ST_T3: begin
        rout_en  = 1'b1;
        rout_sel = rb;
        Yin      = 1'b1;
        state_d  = ST_T4;
      end
      ST_T4: begin
        rout_en  = 1'b1;
        rout_sel = rc;
        ALUop    = op_info.aluop;
        Zlowin   = 1'b1;
        Zhighin  = op_info.muldiv;
        state_d  = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (op_info.muldiv) begin
          LOin    = 1'b1;
          state_d = ST_T6;
        end else begin
          rin_en  = 1'b1;
          state_d = boundary;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = boundary;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_RESET;
    endcase
  end

  reg_select_decoder #(.N(NREGS), .SELW(RSEL_W)) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (ra),
    .onehot_o (Rin)
  );

  reg_select_decoder #(.N(NREGS), .SELW(RSEL_W)) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - self-checking bench for alu_control_sequencer
module tb_alu_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, marin, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, incpc, read;
    logic [3:0] aluop;
    logic halted;
  } ctl_t;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] IR;
  logic        stop;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read;
  logic [3:0] ALUop;
  logic halted;
  ctl_t obs;

  int compared   = 0;
  int mismatched = 0;

  alu_control_sequencer dut (
    .clock(clock), .clear_n(clear_n), .IR(IR), .stop(stop),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .ALUop(ALUop),
    .halted(halted)
  );

  assign obs = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
                ALUop, halted};

  always #5 clock = ~clock;

  // ALU code for each opcode, -1 when the opcode has no execute phase
  function automatic int alu_of(logic [4:0] op);
    case (op)
      5'b00000: return 0;
      5'b00001: return 1;
      5'b00010: return 2;
      5'b00011: return 3;
      5'b00110: return 4;
      5'b00100: return 5;
      5'b00101: return 6;
      5'b00111: return 7;
      5'b01000: return 8;
      5'b01111: return 9;
      5'b10000: return 10;
      default:  return -1;
    endcase
  endfunction

  // phase 0..6 = T0..T6, 7 = halted, anything else = reset
  function automatic ctl_t expect_at(int ph, logic [31:0] ir);
    ctl_t e;
    int   a;
    e = '0;
    a = alu_of(ir[31:27]);
    case (ph)
      0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
      1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
      2: begin e.mdrout = 1; e.irin = 1; end
      3: begin e.rout = 16'h1 << ir[22:19]; e.yin = 1; end
      4: begin
        e.rout    = 16'h1 << ir[18:15];
        e.aluop   = 4'(a);
        e.zlowin  = 1;
        e.zhighin = (a >= 9);
      end
      5: begin
        e.zlowout = 1;
        if (a >= 9) e.loin = 1;
        else        e.rin  = 16'h1 << ir[26:23];
      end
      6: begin e.zhighout = 1; e.hiin = 1; end
      7: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic stop_level(int mode, int ph);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      2:       return (ph >= 3);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, ctl_t e);
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts in T0 and leaves the FSM in T0 again (via clear_n if it halted)
  task automatic run_instr(string tag, logic [31:0] ir, logic stop_val, int mode);
    int   a;
    logic halt_next;
    a  = alu_of(ir[31:27]);
    IR = ir;
    chk({tag, "/T0"}, expect_at(0, ir));
    stop = stop_level(mode, 0);
    tick();
    chk({tag, "/T1"}, expect_at(1, ir));
    stop = stop_level(mode, 1);
    tick();
    chk({tag, "/T2"}, expect_at(2, ir));
    if (a < 0 && ir[31:27] != 5'b11011) begin
      stop      = stop_val;
      halt_next = stop_val;
    end else begin
      stop      = stop_level(mode, 2);
      halt_next = (ir[31:27] == 5'b11011);
    end
    tick();
    if (a >= 0) begin
      chk({tag, "/T3"}, expect_at(3, ir));
      stop = stop_level(mode, 3);
      tick();
      chk({tag, "/T4"}, expect_at(4, ir));
      stop = stop_level(mode, 4);
      tick();
      chk({tag, "/T5"}, expect_at(5, ir));
      if (a >= 9) begin
        stop = stop_level(mode, 5);
        tick();
        chk({tag, "/T6"}, expect_at(6, ir));
      end
      stop      = stop_val;
      halt_next = stop_val;
      tick();
    end
    stop = 1'b0;
    if (halt_next) begin
      for (int i = 0; i < 10; i++) begin
        chk({tag, "/HALT"}, expect_at(7, ir));
        stop = stop_level(mode, 9);
        tick();
      end
      chk({tag, "/HALT_END"}, expect_at(7, ir));
      stop    = 1'b0;
      clear_n = 1'b0;
      tick();
      chk({tag, "/RESET"}, expect_at(-1, ir));
      clear_n = 1'b1;
      tick();
    end
  endtask

  logic [4:0]  legal_ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                  5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01111,
                                  5'b10000};
  logic [31:0] rnd_ir;
  logic [4:0]  rnd_op;

  initial begin
    clear_n = 1'b0;
    IR      = 32'h0;
    stop    = 1'b1;
    tick();
    tick();
    chk("reset", expect_at(-1, 32'h0));
    stop    = 1'b0;
    clear_n = 1'b1;
    tick();

    run_instr("shra", 32'h2B820000, 1'b0, 0);
    run_instr("mul",  32'h781A8000, 1'b0, 0);
    run_instr("halt", 32'hD8000000, 1'b0, 0);
    run_instr("ill",  32'hF8000000, 1'b0, 0);
    run_instr("nop_stop", 32'hD0000000, 1'b1, 0);
    run_instr("add_stop", 32'h01090000, 1'b1, 2);

    // clear_n asserted in T4 aborts the instruction before any Rin pulse
    IR = 32'h01090000;
    chk("abort/T0", expect_at(0, IR));
    tick();
    chk("abort/T1", expect_at(1, IR));
    tick();
    chk("abort/T2", expect_at(2, IR));
    tick();
    chk("abort/T3", expect_at(3, IR));
    tick();
    chk("abort/T4", expect_at(4, IR));
    clear_n = 1'b0;
    tick();
    chk("abort/RESET", expect_at(-1, IR));
    clear_n = 1'b1;
    tick();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) rnd_op = legal_ops[$urandom_range(0, 10)];
      else                           rnd_op = 5'($urandom_range(0, 31));
      rnd_ir = {rnd_op, 27'($urandom)};
      run_instr("rnd", rnd_ir, ($urandom_range(0, 7) == 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
